timer_apb_master: RTL and testbench

- Host-side APB master that drives the timer's APB slave port: tim_psel, tim_penable, tim_pwrite, tim_paddr, tim_pwdata and tim_pstrb.
- Accepts single read/write commands over a valid/ready handshake and sequences the APB SETUP and ACCESS phases.
- Waits on tim_pready and returns read data and error status to the host as a one-cycle response pulse.
- A watchdog aborts any transfer that stalls longer than TIMEOUT cycles, so a hung slave cannot lock up the host.

---
 rtl/timer_apb_master.sv | 194 +++++++++++++++++++
 tb/tb_timer_apb_master.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_apb_master.sv
// Host-side APB master for the timer slave: single read/write commands over valid/ready,
// SETUP/ACCESS sequencing, one-cycle response pulse and an ACCESS-phase watchdog.
module timer_apb_master #(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_W-1:0]     cmd_addr,
  input  logic [DATA_W-1:0]     cmd_wdata,
  input  logic [DATA_W/8-1:0]   cmd_strb,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic                  busy,
  output logic                  tim_psel,
  output logic                  tim_penable,
  output logic                  tim_pwrite,
  output logic [ADDR_W-1:0]     tim_paddr,
  output logic [DATA_W-1:0]     tim_pwdata,
  output logic [DATA_W/8-1:0]   tim_pstrb,
  input  logic [DATA_W-1:0]     tim_prdata,
  input  logic                  tim_pready,
  input  logic                  tim_pslverr
);

  localparam int STRB_W = DATA_W / 8;
  localparam logic [CNT_W-1:0] WDOG_LAST = (TIMEOUT == 0) ? {CNT_W{1'b0}} : CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;
  logic                rsp_timeout_q, rsp_timeout_d;
  logic                busy_q, busy_d;
  logic                psel_q, psel_d;
  logic                penable_q, penable_d;
  logic                pwrite_q, pwrite_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;
  logic [STRB_W-1:0]   pstrb_q, pstrb_d;
  logic [CNT_W-1:0]    wdog_q, wdog_d;

  logic accept_s;
  logic done_s;
  logic expire_s;

  assign accept_s = (state_q == S_IDLE) && cmd_valid && cmd_ready_q;
  assign done_s   = (state_q == S_ACCESS) && tim_pready;
  // A completing pready takes priority over a watchdog expiry in the same cycle.
  assign expire_s = (state_q == S_ACCESS) && !tim_pready && (TIMEOUT != 0) && (wdog_q == WDOG_LAST);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   state_d = accept_s ? S_SETUP : S_IDLE;
      S_SETUP:  state_d = S_ACCESS;
      S_ACCESS: state_d = (done_s || expire_s) ? S_IDLE : S_ACCESS;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready_d   = cmd_ready_q;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = 1'b0;
    rsp_timeout_d = 1'b0;
    psel_d        = psel_q;
    penable_d     = penable_q;
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    pstrb_d       = pstrb_q;
    wdog_d        = wdog_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          cmd_ready_d = 1'b0;
          psel_d      = 1'b1;
          penable_d   = 1'b0;
          pwrite_d    = cmd_write;
          paddr_d     = cmd_addr;
          pwdata_d    = cmd_wdata;
          pstrb_d     = cmd_write ? cmd_strb : {STRB_W{1'b0}};
        end else begin
          cmd_ready_d = 1'b1;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
        end
      end
      S_SETUP: begin
        cmd_ready_d = 1'b0;
        penable_d   = 1'b1;
        wdog_d      = {CNT_W{1'b0}};
      end
      S_ACCESS: begin
        if (done_s) begin
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = pwrite_q ? {DATA_W{1'b0}} : tim_prdata;
          rsp_err_d   = tim_pslverr;
          cmd_ready_d = 1'b1;
          wdog_d      = {CNT_W{1'b0}};
        end else if (expire_s) begin
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = {DATA_W{1'b0}};
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
          cmd_ready_d   = 1'b1;
          wdog_d        = {CNT_W{1'b0}};
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      default: begin
        cmd_ready_d = 1'b0;
        psel_d      = 1'b0;
        penable_d   = 1'b0;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cmd_ready_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= {DATA_W{1'b0}};
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
      busy_q        <= 1'b0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= {ADDR_W{1'b0}};
      pwdata_q      <= {DATA_W{1'b0}};
      pstrb_q       <= {STRB_W{1'b0}};
      wdog_q        <= {CNT_W{1'b0}};
    end else begin
      cmd_ready_q   <= cmd_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
      busy_q        <= busy_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      pstrb_q       <= pstrb_d;
      wdog_q        <= wdog_d;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;
  assign busy        = busy_q;
  assign tim_psel    = psel_q;
  assign tim_penable = penable_q;
  assign tim_pwrite  = pwrite_q;
  assign tim_paddr   = paddr_q;
  assign tim_pwdata  = pwdata_q;
  assign tim_pstrb   = pstrb_q;

endmodule

// File: tb/tb_timer_apb_master.sv
// Directed bench for timer_apb_master: one instance with TIMEOUT=16 and a shadow
// instance with TIMEOUT=0 driven by the same stimulus.
module tb_timer_apb_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_write;
  logic [11:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_strb;
  logic [31:0] prdata;
  logic        pready, pslverr;

  logic        cmd_ready, rsp_valid, rsp_err, rsp_timeout, busy;
  logic        psel, penable, pwrite;
  logic [31:0] rsp_rdata, pwdata;
  logic [11:0] paddr;
  logic [3:0]  pstrb;

  logic        cmd_ready_z, rsp_valid_z, rsp_err_z, rsp_timeout_z, busy_z;
  logic        psel_z, penable_z, pwrite_z;
  logic [31:0] rsp_rdata_z, pwdata_z;
  logic [11:0] paddr_z;
  logic [3:0]  pstrb_z;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  timer_apb_master #(.ADDR_W(12), .DATA_W(32), .TIMEOUT(16), .CNT_W(8)) u_dut (
    .sys_clk(clk), .sys_rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .rsp_timeout(rsp_timeout), .busy(busy),
    .tim_psel(psel), .tim_penable(penable), .tim_pwrite(pwrite),
    .tim_paddr(paddr), .tim_pwdata(pwdata), .tim_pstrb(pstrb),
    .tim_prdata(prdata), .tim_pready(pready), .tim_pslverr(pslverr)
  );

  timer_apb_master #(.ADDR_W(12), .DATA_W(32), .TIMEOUT(0), .CNT_W(8)) u_dut_z (
    .sys_clk(clk), .sys_rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_z), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid_z), .rsp_rdata(rsp_rdata_z), .rsp_err(rsp_err_z),
    .rsp_timeout(rsp_timeout_z), .busy(busy_z),
    .tim_psel(psel_z), .tim_penable(penable_z), .tim_pwrite(pwrite_z),
    .tim_paddr(paddr_z), .tim_pwdata(pwdata_z), .tim_pstrb(pstrb_z),
    .tim_prdata(prdata), .tim_pready(pready), .tim_pslverr(pslverr)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input logic w, input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_strb  = s;
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 12'h000;
    cmd_wdata = 32'h0; cmd_strb = 4'h0; prdata = 32'h0; pready = 1'b0; pslverr = 1'b0;

    // Reset state
    tick(); tick();
    chk("rst_cmd_ready", {63'd0, cmd_ready}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_psel", {63'd0, psel}, 64'd0);
    chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    rst_n = 1'b1;
    #1 chk("rel_cmd_ready_low", {63'd0, cmd_ready}, 64'd0);
    tick();
    chk("rel_cmd_ready_high", {63'd0, cmd_ready}, 64'd1);

    // Write, zero wait states
    set_cmd(1'b1, 12'h000, 32'h0000_0003, 4'hF);
    pready = 1'b1;
    tick();
    cmd_valid = 1'b0;
    chk("w_setup_psel", {63'd0, psel}, 64'd1);
    chk("w_setup_penable", {63'd0, penable}, 64'd0);
    chk("w_setup_pwrite", {63'd0, pwrite}, 64'd1);
    chk("w_setup_pwdata", {32'd0, pwdata}, 64'h3);
    chk("w_setup_pstrb", {60'd0, pstrb}, 64'hF);
    chk("w_setup_cmd_ready", {63'd0, cmd_ready}, 64'd0);
    chk("w_setup_busy", {63'd0, busy}, 64'd1);
    tick();
    chk("w_access_penable", {63'd0, penable}, 64'd1);
    chk("w_access_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    tick();
    chk("w_rsp_valid", {63'd0, rsp_valid}, 64'd1);
    chk("w_rsp_err", {63'd0, rsp_err}, 64'd0);
    chk("w_rsp_rdata", {32'd0, rsp_rdata}, 64'd0);
    chk("w_rsp_psel", {63'd0, psel}, 64'd0);
    chk("w_rsp_busy", {63'd0, busy}, 64'd0);
    chk("w_rsp_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    tick();
    chk("w_rsp_pulse", {63'd0, rsp_valid}, 64'd0);

    // Read, two wait states
    pready = 1'b0;
    set_cmd(1'b0, 12'h004, 32'h1234_5678, 4'hF);
    tick();
    cmd_valid = 1'b0;
    chk("r_pstrb_zero", {60'd0, pstrb}, 64'h0);
    chk("r_pwrite", {63'd0, pwrite}, 64'd0);
    tick();
    chk("r_acc1_paddr", {52'd0, paddr}, 64'h004);
    tick();
    chk("r_acc2_psel", {63'd0, psel}, 64'd1);
    chk("r_acc2_paddr", {52'd0, paddr}, 64'h004);
    tick();
    chk("r_acc3_penable", {63'd0, penable}, 64'd1);
    chk("r_acc3_paddr", {52'd0, paddr}, 64'h004);
    chk("r_acc3_no_rsp", {63'd0, rsp_valid}, 64'd0);
    pready = 1'b1; prdata = 32'hDEAD_BEEF;
    tick();
    chk("r_rsp_valid", {63'd0, rsp_valid}, 64'd1);
    chk("r_rsp_rdata", {32'd0, rsp_rdata}, 64'hDEAD_BEEF);
    chk("r_rsp_err", {63'd0, rsp_err}, 64'd0);
    pready = 1'b0; prdata = 32'h0;
    tick();
    chk("r_rdata_hold", {32'd0, rsp_rdata}, 64'hDEAD_BEEF);

    // Slave error; pready/pslverr high early must be ignored outside ACCESS
    pready = 1'b1; pslverr = 1'b1;
    set_cmd(1'b1, 12'hFFC, 32'hA5A5_A5A5, 4'h3);
    tick();
    cmd_valid = 1'b0;
    chk("e_paddr", {52'd0, paddr}, 64'hFFC);
    chk("e_pstrb", {60'd0, pstrb}, 64'h3);
    chk("e_setup_no_rsp", {63'd0, rsp_valid}, 64'd0);
    tick();
    chk("e_access_psel", {63'd0, psel}, 64'd1);
    tick();
    chk("e_rsp_valid", {63'd0, rsp_valid}, 64'd1);
    chk("e_rsp_err", {63'd0, rsp_err}, 64'd1);
    chk("e_rsp_timeout", {63'd0, rsp_timeout}, 64'd0);
    chk("e_busy", {63'd0, busy}, 64'd0);
    pready = 1'b0; pslverr = 1'b0;
    tick();
    chk("e_err_pulse", {63'd0, rsp_err}, 64'd0);

    // Watchdog: 16 ACCESS cycles then abort; TIMEOUT=0 instance keeps waiting
    prdata = 32'h0000_CAFE;
    set_cmd(1'b0, 12'h010, 32'h0, 4'hF);
    tick();
    cmd_valid = 1'b0;
    tick();
    for (int i = 0; i < 15; i++) begin
      tick();
      chk($sformatf("t_wait_psel_%0d", i), {63'd0, psel}, 64'd1);
    end
    tick();
    chk("t_psel_drop", {63'd0, psel}, 64'd0);
    chk("t_rsp_valid", {63'd0, rsp_valid}, 64'd1);
    chk("t_rsp_err", {63'd0, rsp_err}, 64'd1);
    chk("t_rsp_timeout", {63'd0, rsp_timeout}, 64'd1);
    chk("t_rsp_rdata", {32'd0, rsp_rdata}, 64'd0);
    chk("t_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    chk("t0_still_psel", {63'd0, psel_z}, 64'd1);
    chk("t0_no_rsp", {63'd0, rsp_valid_z}, 64'd0);
    tick();
    chk("t_timeout_pulse", {63'd0, rsp_timeout}, 64'd0);
    repeat (20) tick();
    chk("t0_long_psel", {63'd0, psel_z}, 64'd1);
    chk("t0_long_busy", {63'd0, busy_z}, 64'd1);
    pready = 1'b1; prdata = 32'h0BAD_F00D;
    tick();
    chk("t0_rsp_valid", {63'd0, rsp_valid_z}, 64'd1);
    chk("t0_rsp_rdata", {32'd0, rsp_rdata_z}, 64'h0BAD_F00D);
    chk("t0_rsp_timeout", {63'd0, rsp_timeout_z}, 64'd0);
    chk("t_idle_ignores_pready", {63'd0, rsp_valid}, 64'd0);
    tick();

    // Back-to-back: four commands, pready held high
    pready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_cmd(i[0] ? 1'b0 : 1'b1, 12'h100 + 12'(i * 4), 32'h5000_0000 + 32'(i), 4'hF);
      prdata = 32'h1000_0000 + 32'(i);
      chk($sformatf("b_ready_%0d", i), {63'd0, cmd_ready}, 64'd1);
      tick();
      chk($sformatf("b_setup_psel_%0d", i), {63'd0, psel}, 64'd1);
      chk($sformatf("b_setup_paddr_%0d", i), {52'd0, paddr}, 64'h100 + 64'(i * 4));
      if (i == 3) cmd_valid = 1'b0;
      tick();
      chk($sformatf("b_access_penable_%0d", i), {63'd0, penable}, 64'd1);
      tick();
      chk($sformatf("b_rsp_valid_%0d", i), {63'd0, rsp_valid}, 64'd1);
      chk($sformatf("b_rsp_rdata_%0d", i), {32'd0, rsp_rdata}, i[0] ? 64'h1000_0000 + 64'(i) : 64'd0);
    end
    tick();
    chk("b_idle_after", {63'd0, busy}, 64'd0);

    // Reset during a waited read
    pready = 1'b0;
    set_cmd(1'b0, 12'h020, 32'h0, 4'hF);
    tick();
    cmd_valid = 1'b0;
    tick(); tick();
    chk("x_before_psel", {63'd0, psel}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("x_psel", {63'd0, psel}, 64'd0);
    chk("x_penable", {63'd0, penable}, 64'd0);
    chk("x_busy", {63'd0, busy}, 64'd0);
    chk("x_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    chk("x_cmd_ready", {63'd0, cmd_ready}, 64'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("x_rel_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    chk("x_rel_no_rsp", {63'd0, rsp_valid}, 64'd0);
    pready = 1'b1;
    set_cmd(1'b1, 12'h008, 32'h0000_0077, 4'hF);
    tick();
    cmd_valid = 1'b0;
    chk("x_next_psel", {63'd0, psel}, 64'd1);
    tick();
    tick();
    chk("x_next_rsp_valid", {63'd0, rsp_valid}, 64'd1);
    chk("x_next_rsp_err", {63'd0, rsp_err}, 64'd0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
